// File: rtl/req_gnt_pkg.sv
// Shared types and default widths for the request/grant controller slice.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned GCNT_W_DEF = 8;

endpackage

// File: rtl/cycle_counter.sv
// Free-running counter with synchronous load of an init value.
// wrap_o is high during the cycle the counter holds all-ones, so the edge that rolls it over to zero sees it.
module cycle_counter #(
  parameter int unsigned   W    = 16,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= INIT;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = &count_q;

endmodule

// File: rtl/req_gnt_ctrl.sv
// Grant-side controller: one registered gnt pulse per accepted req, then a recovery cycle.
// Also keeps a saturating grant tally and a sticky interrupt for violations and counter wrap.
module req_gnt_ctrl
  import req_gnt_pkg::*;
#(
  parameter int unsigned       CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0]  CNT_INIT    = '0,
  parameter int unsigned       GCNT_W      = GCNT_W_DEF,
  parameter bit                WRAP_INT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              int_clr,
  output logic              gnt,
  output logic [CNT_W-1:0]  count,
  output logic [GCNT_W-1:0] gnt_cnt,
  output logic              int_sig,
  output logic              viol,
  output logic              wrapped
);

  state_t              state_q, state_d;
  logic                gnt_q;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic                int_q, int_d;
  logic                viol_q, viol_d;
  logic                wrap_q, wrap_d;
  logic                viol_set;
  logic                wrap_set;

  cycle_counter #(
    .W    (CNT_W),
    .INIT (CNT_INIT)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .count_o (count),
    .wrap_o  (wrap_set)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = GRANT;
      GRANT:   state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A req outside IDLE is dropped; it only raises the violation flag.
  assign viol_set = req & (state_q != IDLE);

  always_comb begin
    gcnt_d = gcnt_q;
    if ((state_d == GRANT) && (gcnt_q != '1)) begin
      gcnt_d = gcnt_q + 1'b1;
    end
    viol_d = viol_set | (viol_q & ~int_clr);
    wrap_d = wrap_set | (wrap_q & ~int_clr);
    int_d  = viol_set | (wrap_set & WRAP_INT_EN) | (int_q & ~int_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      gcnt_q  <= '0;
      int_q   <= 1'b0;
      viol_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= (state_d == GRANT);
      gcnt_q  <= gcnt_d;
      int_q   <= int_d;
      viol_q  <= viol_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_cnt = gcnt_q;
  assign int_sig = int_q;
  assign viol    = viol_q;
  assign wrapped = wrap_q;

endmodule

// File: tb/tb_req_gnt_ctrl.sv
// Directed bench for req_gnt_ctrl: per-cycle vector table plus wrap and saturation sequences.
module tb_req_gnt_ctrl;

  typedef struct {
    logic        rst;
    logic        req;
    logic        clr;
    logic        gnt;
    logic [7:0]  gcnt;
    logic [15:0] cnt;
    logic        intr;
    logic        viol;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, req, int_clr;
  logic        gnt, gnt0;
  logic [15:0] count, count0;
  logic [7:0]  gnt_cnt, gnt_cnt0;
  logic        int_sig, int_sig0;
  logic        viol, viol0;
  logic        wrapped, wrapped0;

  int unsigned checks = 0;
  int unsigned failures = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  req_gnt_ctrl #(
    .CNT_W       (16),
    .CNT_INIT    (16'h0000),
    .GCNT_W      (8),
    .WRAP_INT_EN (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .int_clr (int_clr),
    .gnt     (gnt),
    .count   (count),
    .gnt_cnt (gnt_cnt),
    .int_sig (int_sig),
    .viol    (viol),
    .wrapped (wrapped)
  );

  req_gnt_ctrl #(
    .CNT_W       (16),
    .CNT_INIT    (16'h0000),
    .GCNT_W      (8),
    .WRAP_INT_EN (1'b0)
  ) dut0 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .int_clr (int_clr),
    .gnt     (gnt0),
    .count   (count0),
    .gnt_cnt (gnt_cnt0),
    .int_sig (int_sig0),
    .viol    (viol0),
    .wrapped (wrapped0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rs, input logic rq, input logic cl, input logic g,
                     input logic [7:0] gc, input logic [15:0] c, input logic it, input logic vi);
    vec_t v;
    v.rst = rs; v.req = rq; v.clr = cl; v.gnt = g;
    v.gcnt = gc; v.cnt = c; v.intr = it; v.viol = vi;
    vecs.push_back(v);
  endtask

  int unsigned ngnt;
  bit          reached;

  initial begin
    reset = 1'b1; req = 1'b0; int_clr = 1'b0;

    //  rst req clr | gnt gcnt count int viol
    add(1, 0, 0,   0, 0,  0,   0, 0);
    add(1, 0, 0,   0, 0,  0,   0, 0);
    add(1, 0, 0,   0, 0,  0,   0, 0);
    add(0, 0, 0,   0, 0,  1,   0, 0);
    add(0, 0, 0,   0, 0,  2,   0, 0);
    add(0, 1, 0,   1, 1,  3,   0, 0);  // accepted in IDLE
    add(0, 0, 0,   0, 1,  4,   0, 0);  // RECOVER
    add(0, 0, 0,   0, 1,  5,   0, 0);  // IDLE
    add(0, 1, 0,   1, 2,  6,   0, 0);  // req held two cycles
    add(0, 1, 0,   0, 2,  7,   1, 1);  // second cycle is a violation, no grant
    add(0, 1, 0,   0, 2,  8,   1, 1);  // req during RECOVER: violation, dropped
    add(0, 0, 1,   0, 2,  9,   0, 0);  // clear with no new cause
    add(0, 1, 0,   1, 3, 10,   0, 0);
    add(0, 1, 1,   0, 3, 11,   1, 1);  // violation coincident with clear: set wins
    add(0, 0, 1,   0, 3, 12,   0, 0);
    add(0, 1, 0,   1, 4, 13,   0, 0);
    add(1, 0, 0,   0, 0,  0,   0, 0);  // reset during GRANT drops gnt
    add(0, 0, 0,   0, 0,  1,   0, 0);
    add(0, 1, 0,   1, 1,  2,   0, 0);  // granted normally after reset
    add(0, 0, 0,   0, 1,  3,   0, 0);
    add(0, 0, 0,   0, 1,  4,   0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; req = vecs[i].req; int_clr = vecs[i].clr;
      step();
      chk($sformatf("v%0d_gnt", i),     {31'd0, gnt},     {31'd0, vecs[i].gnt});
      chk($sformatf("v%0d_gnt_cnt", i), {24'd0, gnt_cnt}, {24'd0, vecs[i].gcnt});
      chk($sformatf("v%0d_count", i),   {16'd0, count},   {16'd0, vecs[i].cnt});
      chk($sformatf("v%0d_int", i),     {31'd0, int_sig}, {31'd0, vecs[i].intr});
      chk($sformatf("v%0d_viol", i),    {31'd0, viol},    {31'd0, vecs[i].viol});
      chk($sformatf("v%0d_wrapped", i), {31'd0, wrapped}, 32'd0);
    end
    req = 1'b0; int_clr = 1'b0;

    // Saturation of the grant tally with spaced requests
    reset = 1'b1; step(); reset = 1'b0;
    ngnt = 0;
    for (int n = 1; n <= 300; n++) begin
      req = 1'b1; step(); req = 1'b0;
      if (gnt === 1'b1) ngnt++;
      step();
      if (gnt !== 1'b0) chk("sat_gnt_low", {31'd0, gnt}, 32'd0);
      step();
      if (n == 254) chk("sat_cnt_254", {24'd0, gnt_cnt}, 32'd254);
      if (n == 255) chk("sat_cnt_255", {24'd0, gnt_cnt}, 32'd255);
    end
    chk("sat_pulses", ngnt, 32'd300);
    chk("sat_cnt_300", {24'd0, gnt_cnt}, 32'd255);
    chk("sat_no_int", {31'd0, int_sig}, 32'd0);

    // Counter wrap, with and without the wrap interrupt
    reset = 1'b1; step(); reset = 1'b0;
    chk("wrap_start", {16'd0, count}, 32'd0);
    reached = 1'b0;
    for (int unsigned k = 0; k < 70000 && !reached; k++) begin
      if (count === 16'hFFFF) reached = 1'b1;
      else step();
    end
    chk("wrap_reach", {31'd0, reached}, 32'd1);
    chk("wrap_pre_wrapped", {31'd0, wrapped}, 32'd0);
    chk("wrap_pre_int", {31'd0, int_sig}, 32'd0);
    step();
    chk("wrap_count", {16'd0, count}, 32'd0);
    chk("wrap_wrapped", {31'd0, wrapped}, 32'd1);
    chk("wrap_int_en1", {31'd0, int_sig}, 32'd1);
    chk("wrap0_wrapped", {31'd0, wrapped0}, 32'd1);
    chk("wrap0_int", {31'd0, int_sig0}, 32'd0);
    step();
    chk("wrap_sticky", {31'd0, wrapped}, 32'd1);
    int_clr = 1'b1; step(); int_clr = 1'b0;
    chk("wrap_clr_wrapped", {31'd0, wrapped}, 32'd0);
    chk("wrap_clr_int", {31'd0, int_sig}, 32'd0);
    chk("wrap0_clr_wrapped", {31'd0, wrapped0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
